// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the program-counter / fetch-sequencing block.
//   - Default widths and start address.
//   - FSM state encoding (IDLE / RUN / HALT, 2 bits).
//   - Next-PC select codes, shared with the instruction decoder.
package pc_fetch_unit_pkg;

  localparam int D_DEFAULT        = 12;
  localparam int START_PC_DEFAULT = 0;
  localparam int CNT_W_DEFAULT    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_SEQ   = 3'd1,
    PC_ABS   = 3'd2,
    PC_REL   = 3'd3,
    PC_START = 3'd4
  } pc_sel_t;

endpackage

// File: rtl/pc_fetch_unit_next_calc.sv
// pc_next_calc: combinational next-PC multiplexer and modulo-2**D adder.
// Ports:
//   i_sel      next-PC select (hold / sequential / absolute / relative / start)
//   i_pc       current program counter
//   i_target   branch-target table read data (absolute address or offset)
//   o_pc_next  program counter value for the next clock edge
module pc_next_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int D        = D_DEFAULT,
  parameter int START_PC = START_PC_DEFAULT
) (
  input  pc_sel_t        i_sel,
  input  logic [D-1:0]   i_pc,
  input  logic [D-1:0]   i_target,
  output logic [D-1:0]   o_pc_next
);

  localparam logic [D-1:0] START_PC_V = D'(START_PC);

  // D-bit sums drop the carry, so an offset in two's complement gives
  // signed relative addressing and PC 2**D-1 wraps to 0 with no flag.
  always_comb begin
    o_pc_next = i_pc;
    case (i_sel)
      PC_HOLD:  o_pc_next = i_pc;
      PC_SEQ:   o_pc_next = i_pc + {{(D-1){1'b0}}, 1'b1};
      PC_ABS:   o_pc_next = i_target;
      PC_REL:   o_pc_next = i_pc + i_target;
      PC_START: o_pc_next = START_PC_V;
      default:  o_pc_next = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, start/run/halt sequencing and a
// saturating retired-instruction counter. Reads an external branch-target
// table through lut_addr/lut_target (combinational, zero-bubble branches).
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 one-cycle pulse, leaves IDLE or HALT for RUN
//   stall                 freezes everything while in RUN
//   halt                  decoded halt at the current PC
//   branch_en/_taken      branch present / condition true
//   rel_mode              1 = target is an offset, 0 = absolute address
//   lut_idx / lut_addr    table index in / index presented to the table
//   lut_target            table read data
//   prog_ctr              fetch address
//   running / done        state == RUN / state == HALT
//   instr_cnt             retired instructions since the last start
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int D        = D_DEFAULT,
  parameter int START_PC = START_PC_DEFAULT,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic             rel_mode,
  input  logic [3:0]       lut_idx,
  output logic [3:0]       lut_addr,
  input  logic [D-1:0]     lut_target,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [D-1:0]     START_PC_V = D'(START_PC);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_state_next;
  pc_sel_t           w_pc_sel;
  logic              w_cnt_inc;
  logic              w_cnt_clr;
  logic [D-1:0]      r_pc;
  logic [D-1:0]      w_pc_next;
  logic [CNT_W-1:0]  r_cnt;

  // The table is read in the same cycle the index is presented.
  assign lut_addr = lut_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (!stall && halt) w_state_next = HALT;
      HALT:    if (start) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  // Output / datapath control: halt beats a taken branch, which beats
  // sequential fetch. A halt still retires, so it increments the counter.
  always_comb begin
    w_pc_sel  = PC_HOLD;
    w_cnt_inc = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        if (start) begin
          w_pc_sel  = PC_START;
          w_cnt_clr = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          w_cnt_inc = 1'b1;
          if (halt) begin
            w_pc_sel = PC_HOLD;
          end else if (branch_en && branch_taken) begin
            w_pc_sel = rel_mode ? PC_REL : PC_ABS;
          end else begin
            w_pc_sel = PC_SEQ;
          end
        end
      end
      default: w_pc_sel = PC_HOLD;
    endcase
  end

  pc_next_calc #(
    .D        (D),
    .START_PC (START_PC)
  ) u_next_calc (
    .i_sel     (w_pc_sel),
    .i_pc      (r_pc),
    .i_target  (lut_target),
    .o_pc_next (w_pc_next)
  );

  // PC and saturating counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= START_PC_V;
      r_cnt <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign prog_ctr  = r_pc;
  assign instr_cnt = r_cnt;
  assign running   = (r_state == RUN);
  assign done      = (r_state == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int D    = 12;
  localparam int MODV = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        branch_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic        rel_mode = 1'b0;
  logic [3:0]  lut_idx = 4'h0;

  logic [D-1:0] lut_mem [16];

  // DUT A: default 16-bit counter; DUT B: 4-bit counter for saturation.
  logic [3:0]   lut_addr_a, lut_addr_b;
  logic [D-1:0] lut_tgt_a, lut_tgt_b;
  logic [D-1:0] pc_a, pc_b;
  logic         run_a, run_b, done_a, done_b;
  logic [15:0]  cnt_a;
  logic [3:0]   cnt_b;

  assign lut_tgt_a = lut_mem[lut_addr_a];
  assign lut_tgt_b = lut_mem[lut_addr_b];

  pc_fetch_unit #(.D(D), .START_PC(0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken), .rel_mode(rel_mode),
    .lut_idx(lut_idx), .lut_addr(lut_addr_a), .lut_target(lut_tgt_a),
    .prog_ctr(pc_a), .running(run_a), .done(done_a), .instr_cnt(cnt_a));

  pc_fetch_unit #(.D(D), .START_PC(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_taken(branch_taken), .rel_mode(rel_mode),
    .lut_idx(lut_idx), .lut_addr(lut_addr_b), .lut_target(lut_tgt_b),
    .prog_ctr(pc_b), .running(run_b), .done(done_b), .instr_cnt(cnt_b));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: 0 = idle, 1 = run, 2 = halted.
  int m_st = 0, m_pc = 0, m_cnt16 = 0, m_cnt4 = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    int t;
    t = int'(lut_mem[lut_idx]);
    if (reset) begin
      m_st <= 0; m_pc <= 0; m_cnt16 <= 0; m_cnt4 <= 0; m_valid <= 1;
    end else if (m_st == 0 || m_st == 2) begin
      if (start) begin
        m_st <= 1; m_pc <= 0; m_cnt16 <= 0; m_cnt4 <= 0;
      end
    end else if (!stall) begin
      m_cnt16 <= (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
      m_cnt4  <= (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
      if (halt)                          m_st <= 2;
      else if (branch_en && branch_taken) m_pc <= rel_mode ? (m_pc + t) % MODV : t;
      else                               m_pc <= (m_pc + 1) % MODV;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc_a", int'(pc_a), m_pc);
      chk("run_a", int'(run_a), int'(m_st == 1));
      chk("done_a", int'(done_a), int'(m_st == 2));
      chk("cnt_a", int'(cnt_a), m_cnt16);
      chk("lut_addr_a", int'(lut_addr_a), int'(lut_idx));
      chk("pc_b", int'(pc_b), m_pc);
      chk("run_b", int'(run_b), int'(m_st == 1));
      chk("done_b", int'(done_b), int'(m_st == 2));
      chk("cnt_b", int'(cnt_b), m_cnt4);
    end
  end

  task automatic drive(input bit r, input bit s, input bit st, input bit h,
                       input bit be, input bit bt, input bit rel, input logic [3:0] idx);
    reset = r; start = s; stall = st; halt = h;
    branch_en = be; branch_taken = bt; rel_mode = rel; lut_idx = idx;
    @(posedge clk);
    #1;
    $display("txn t=%0t rst=%0b start=%0b stall=%0b halt=%0b br=%0b%0b rel=%0b idx=%0h -> pc=%03h run=%0b done=%0b cnt=%0d cnt4=%0d",
             $time, r, s, st, h, be, bt, rel, idx, pc_a, run_a, done_a, cnt_a, cnt_b);
  endtask

  task automatic seq(); drive(0, 0, 0, 0, 0, 0, 0, 4'h0); endtask

  initial begin
    for (int i = 0; i < 16; i++) lut_mem[i] = D'(i * 37);
    lut_mem[1] = 12'hFFF;
    lut_mem[2] = 12'h014;
    lut_mem[3] = 12'h001;
    lut_mem[4] = 12'hFFB;
    lut_mem[5] = 12'h000;

    // Reset state.
    drive(1, 0, 0, 0, 0, 0, 0, 4'h0);
    chk("rst_pc", int'(pc_a), 0);
    chk("rst_run", int'(run_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);

    // Start and five sequential fetches.
    drive(0, 1, 0, 0, 0, 0, 0, 4'h0);
    chk("start_pc", int'(pc_a), 0);
    chk("start_run", int'(run_a), 1);
    for (int i = 1; i <= 5; i++) begin
      seq();
      chk("seq_pc", int'(pc_a), i);
    end
    chk("seq_cnt", int'(cnt_a), 5);

    // Relative branches and wrap.
    drive(0, 0, 0, 0, 1, 1, 1, 4'h1);   // 5 - 1 = 4
    drive(0, 0, 0, 0, 1, 1, 1, 4'h1);   // 4 - 1 = 3
    chk("rel_m1", int'(pc_a), 3);
    drive(0, 0, 0, 0, 1, 1, 1, 4'h3);   // 3 + 1 = 4
    drive(0, 0, 0, 0, 1, 1, 1, 4'h4);   // 4 - 5 = FFF
    chk("rel_m5", int'(pc_a), 12'hFFF);
    seq();
    chk("wrap", int'(pc_a), 0);

    // Absolute branch: index visible on lut_addr combinationally.
    lut_idx = 4'h2; branch_en = 1; branch_taken = 1; rel_mode = 0;
    #1;
    chk("lut_addr_comb", int'(lut_addr_a), 2);
    drive(0, 0, 0, 0, 1, 1, 0, 4'h2);
    chk("abs_pc", int'(pc_a), 20);
    drive(0, 0, 0, 0, 1, 0, 0, 4'h2);
    chk("not_taken", int'(pc_a), 21);
    drive(0, 0, 0, 0, 1, 1, 1, 4'h5);   // zero-offset self-loop
    chk("self_loop_pc", int'(pc_a), 21);
    chk("self_loop_cnt", int'(cnt_a), 13);

    // Stall masks halt, then halt takes effect.
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 1, 1, 0, 4'h2);
    chk("stall_pc", int'(pc_a), 21);
    chk("stall_cnt", int'(cnt_a), 13);
    chk("stall_run", int'(run_a), 1);
    drive(0, 0, 0, 1, 1, 1, 0, 4'h2);
    chk("halt_done", int'(done_a), 1);
    chk("halt_pc", int'(pc_a), 21);
    chk("halt_cnt", int'(cnt_a), 14);
    drive(0, 0, 0, 0, 1, 1, 0, 4'h2);
    drive(0, 0, 1, 1, 0, 0, 0, 4'h0);
    chk("halt_hold_pc", int'(pc_a), 21);
    drive(0, 1, 0, 0, 0, 0, 0, 4'h0);
    chk("restart_pc", int'(pc_a), 0);
    chk("restart_cnt", int'(cnt_a), 0);
    chk("restart_run", int'(run_a), 1);

    // Reset mid-RUN with a taken branch, then reset together with start.
    for (int i = 0; i < 9; i++) seq();
    chk("pre_rst_pc", int'(pc_a), 9);
    drive(1, 0, 0, 0, 1, 1, 0, 4'h2);
    chk("midrst_pc", int'(pc_a), 0);
    chk("midrst_run", int'(run_a), 0);
    chk("midrst_cnt", int'(cnt_a), 0);
    drive(1, 1, 0, 0, 0, 0, 0, 4'h0);
    chk("rst_start_run", int'(run_a), 0);

    // Counter saturation on the 4-bit instance.
    drive(0, 1, 0, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 20; i++) seq();
    chk("sat_cnt4", int'(cnt_b), 15);
    chk("sat_cnt16", int'(cnt_a), 20);
    chk("sat_pc", int'(pc_b), 20);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) lut_mem[$urandom_range(0, 15)] = D'($urandom);
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 4'($urandom));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing block; consumer and reader of the branch-target lookup table.
- Drives the 4-bit table index and receives the D-bit target; the target is an absolute address or a two's-complement offset.
- Owns the PC register, the start/run/halt state machine and a retired-instruction counter.
- Sits between the instruction decoder (branch/halt controls) and instruction memory (PC as fetch address).

Parameters:
D, 12, PC and branch-target width; all PC arithmetic is modulo 2**D
START_PC, 0, PC value loaded on reset and on every start
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins execution from IDLE or HALT
stall  input  1  freezes PC, state and counter for this cycle
halt  input  1  decoded halt instruction at current PC
branch_en  input  1  current instruction is a branch
branch_taken  input  1  branch condition true; meaningful only with branch_en
rel_mode  input  1  1 = target is signed offset added to PC; 0 = absolute target
lut_idx  input  4  table index field from the current instruction
lut_addr  output  4  index presented to the target table
lut_target  input  D  table read data, combinational from lut_addr
prog_ctr  output  D  current fetch address
running  output  1  high while in RUN
done  output  1  high while in HALT
instr_cnt  output  CNT_W  retired instructions since last start

Behaviour:
- Reset (synchronous, active-high, highest priority): state=IDLE, prog_ctr=START_PC, running=0, done=0, instr_cnt=0. Reset asserted mid-RUN takes effect at that edge. The previous branch/halt controls are discarded.
- lut_addr = lut_idx, combinational and unregistered in every state. The table read completes in the same cycle, so a taken branch has zero bubble.
- States: IDLE, RUN, HALT. running = (state==RUN). done = (state==HALT). Both outputs are registered state decodes.
- IDLE: PC holds. start=1 -> RUN next edge, prog_ctr=START_PC, instr_cnt=0. stall is ignored in IDLE.
- RUN, stall=1: no state change at all. PC, counter and state hold, and halt/branch/start are ignored.
- RUN, stall=0, priority halt > taken branch > sequential:
  - halt=1 -> HALT. PC holds at the halt address. instr_cnt increments, because halt counts as retired.
  - branch_en=1, branch_taken=1, rel_mode=0 -> prog_ctr = lut_target.
  - branch_en=1, branch_taken=1, rel_mode=1 -> prog_ctr = (prog_ctr + lut_target) mod 2**D. Plain D-bit add with carry discarded, which is equivalent to signed offset addition.
  - Otherwise -> prog_ctr = (prog_ctr + 1) mod 2**D. 2**D-1 wraps to 0 with no flag.
  - branch_en=1 with branch_taken=0 -> sequential.
  - instr_cnt increments on every non-stalled RUN cycle and saturates at all-ones with no wrap.
- RUN: start is ignored.
- HALT: PC and instr_cnt hold. done stays 1. start=1 -> RUN, prog_ctr=START_PC, instr_cnt=0. All other inputs are ignored.
- Simultaneous start and reset: reset wins, and the block lands in IDLE.
- A relative offset of 0 is a legal self-loop. The PC is unchanged and the counter still increments.
- No X propagation: every output is driven from registers or lut_idx in all states.

Decomposition:
- Shared package:
  - D and START_PC defaults.
  - State enum {IDLE, RUN, HALT} with a 2-bit encoding.
  - Next-PC select enum {PC_HOLD, PC_SEQ, PC_ABS, PC_REL, PC_START}. The decoder uses the same enum.
- One natural sub-module, pc_next_calc: combinational next-PC mux and modulo adder, from prog_ctr, lut_target and the select.
- FSM and counter stay in the top module.
- The target table itself remains an external instance wired through lut_addr/lut_target.

Test Plan:
1. Reset, start, then 5 non-stalled cycles with no branch -> prog_ctr 0,1,2,3,4,5; instr_cnt=5; running=1.
2. At prog_ctr=4, relative branch:
   - lut_target=12'hFFF -> prog_ctr=3.
   - From 4 again, lut_target=12'hFFB (-5) -> prog_ctr=12'hFFF.
   - From 12'hFFF, sequential -> 0 (wrap).
3. Absolute branch, lut_idx=4'h2 with the table returning 12'h014 -> lut_addr=2 in the same cycle, prog_ctr=20 next edge. Repeat with branch_taken=0 -> prog_ctr=PC+1.
4. Stall and halt ordering:
   - stall=1 with halt=1 for 3 cycles -> PC and instr_cnt frozen, still RUN.
   - Drop stall -> HALT, done=1, PC holds.
   - start -> prog_ctr=0, instr_cnt=0, running=1.
5. reset asserted mid-RUN at prog_ctr=9, simultaneously with a taken branch -> next edge prog_ctr=START_PC, IDLE, done=0, running=0, instr_cnt=0.
6. Counter saturation, CNT_W=4 override: run 20 cycles -> instr_cnt stops at 4'hF.
